aes_valu_sequencer: RTL and testbench

//  FSM that runs a full AES-128 encryption by issuing ops to an external vector_alu:
//  on-the-fly key expansion interleaved with the round transforms.

---
 rtl/vector_alu_pkg.sv | 69 ++++++
 rtl/vector_alu.sv | 66 ++++++
 rtl/aes_valu_sequencer.sv | 151 +++++++++++++++
 tb/tb_aes_valu_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_alu_pkg.sv
// Shared definitions for the vector ALU and the AES sequencer that drives it:
// ALU op codes, the AES round constants, the sequencer FSM states and the
// GF(2^8) helpers used by the byte-wise ALU ops.
package vector_alu_pkg;

    typedef enum logic [3:0] {
        VALU_XOR         = 4'd0,
        VALU_ROT         = 4'd1,
        VALU_SUBBYTES    = 4'd2,
        VALU_KEYSCHE     = 4'd3,
        VALU_SHIFTROWS   = 4'd4,
        VALU_MIX_COLUMNS = 4'd5
    } valu_op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARK0,
        S_KS_ROT,
        S_KS_SUB,
        S_KS_XOR,
        S_SB,
        S_SR,
        S_MC,
        S_DONE
    } seq_state_e;

    // Round constant, indexed by round number 1..10; lives in the top byte of a key word.
    localparam logic [7:0] AES_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as x^254 (square-and-multiply), then the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Rotate a 32-bit lane left by n bits.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

endpackage

// File: rtl/vector_alu.sv
// Combinational 128-bit vector ALU. State layout: byte i at [127-8i -: 8],
// byte i is row i%4, column i/4; key word 0 occupies [127:96].
// Byte-wise ops fold a final XOR with op2 so a round key can be added in the same op.
module vector_alu
    import vector_alu_pkg::*;
(
    input  logic [127:0] op1,
    input  logic [127:0] op2,
    input  logic [3:0]   ctrl,
    output logic [127:0] result
);

    logic [127:0] sb_w;
    logic [127:0] sr_w;
    logic [127:0] mc_w;
    logic [127:0] rot_w;
    logic [31:0]  ks_w0;
    logic [31:0]  ks_w1;
    logic [31:0]  ks_w2;
    logic [31:0]  ks_w3;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            assign sb_w[127-8*gi -: 8] = aes_sbox(op1[127-8*gi -: 8]);
            assign sr_w[127-8*gi -: 8] = op1[127-8*(4*((COL+ROW)%4)+ROW) -: 8];
        end
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] a0, a1, a2, a3;
            assign a0 = op1[127-32*gi -: 8];
            assign a1 = op1[119-32*gi -: 8];
            assign a2 = op1[111-32*gi -: 8];
            assign a3 = op1[103-32*gi -: 8];
            assign mc_w[127-32*gi -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
            assign rot_w[32*gi +: 32] = rotl32(op1[32*gi +: 32], op2[4:0]);
        end
    endgenerate

    // Key-schedule chain: each new word is the old word XOR the previous new word.
    assign ks_w0 = op1[127:96] ^ op2[31:0];
    assign ks_w1 = op1[95:64]  ^ ks_w0;
    assign ks_w2 = op1[63:32]  ^ ks_w1;
    assign ks_w3 = op1[31:0]   ^ ks_w2;

    // Op select.
    always_comb begin
        result = '0;
        case (ctrl)
            VALU_XOR:         result = op1 ^ op2;
            VALU_ROT:         result = rot_w;
            VALU_SUBBYTES:    result = sb_w ^ op2;
            VALU_KEYSCHE:     result = {ks_w0, ks_w1, ks_w2, ks_w3};
            VALU_SHIFTROWS:   result = sr_w ^ op2;
            VALU_MIX_COLUMNS: result = mc_w ^ op2;
            default:          result = '0;
        endcase
    end

endmodule

// File: rtl/aes_valu_sequencer.sv
// AES-128 encrypt sequencer. Issues one vector ALU op per cycle and captures the
// combinational result at the end of that cycle; the round key is expanded on the
// fly just before each round uses it.
module aes_valu_sequencer
    import vector_alu_pkg::*;
#(
    parameter int WIDTH   = 128,
    parameter int NROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_key,
    input  logic [WIDTH-1:0] in_block,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_block,
    output logic             busy,
    output logic [3:0]       round_idx,
    output logic [WIDTH-1:0] valu_op1,
    output logic [WIDTH-1:0] valu_op2,
    output logic [3:0]       valu_ctrl,
    input  logic [WIDTH-1:0] valu_result
);

    localparam logic [3:0]       LAST_ROUND = 4'(NROUNDS);
    localparam logic [WIDTH-1:0] ROT_BYTE   = WIDTH'(8);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] st_q, st_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [WIDTH-1:0] tmp_q, tmp_d;
    logic [3:0]       round_idx_q, round_idx_d;
    logic [WIDTH-1:0] out_block_q, out_block_d;
    logic             out_valid_q, out_valid_d;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = ~in_ready;
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;
    assign round_idx = round_idx_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            st_q        <= '0;
            key_q       <= '0;
            tmp_q       <= '0;
            round_idx_q <= '0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            key_q       <= key_d;
            tmp_q       <= tmp_d;
            round_idx_q <= round_idx_d;
            out_block_q <= out_block_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state, ALU op issue and result capture.
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        key_d       = key_q;
        tmp_d       = tmp_q;
        round_idx_d = round_idx_q;
        out_block_d = out_block_q;
        out_valid_d = out_valid_q;
        valu_op1    = '0;
        valu_op2    = '0;
        valu_ctrl   = VALU_XOR;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = in_block;
                    key_d   = in_key;
                    state_d = S_ARK0;
                end
            end
            S_ARK0: begin
                valu_ctrl   = VALU_XOR;
                valu_op1    = st_q;
                valu_op2    = key_q;
                st_d        = valu_result;
                round_idx_d = 4'd1;
                state_d     = S_KS_ROT;
            end
            S_KS_ROT: begin
                valu_ctrl = VALU_ROT;
                valu_op1  = key_q;
                valu_op2  = ROT_BYTE;
                tmp_d     = valu_result;
                state_d   = S_KS_SUB;
            end
            S_KS_SUB: begin
                valu_ctrl = VALU_SUBBYTES;
                valu_op1  = tmp_q;
                valu_op2  = {{(WIDTH-32){1'b0}}, AES_RCON[round_idx_q], 24'h0};
                tmp_d     = valu_result;
                state_d   = S_KS_XOR;
            end
            S_KS_XOR: begin
                valu_ctrl = VALU_KEYSCHE;
                valu_op1  = key_q;
                valu_op2  = {{(WIDTH-32){1'b0}}, tmp_q[31:0]};
                key_d     = valu_result;
                state_d   = S_SB;
            end
            S_SB: begin
                valu_ctrl = VALU_SUBBYTES;
                valu_op1  = st_q;
                st_d      = valu_result;
                state_d   = S_SR;
            end
            S_SR: begin
                // The last round has no MixColumns, so its round key rides on ShiftRows.
                valu_ctrl = VALU_SHIFTROWS;
                valu_op1  = st_q;
                valu_op2  = (round_idx_q == LAST_ROUND) ? key_q : '0;
                st_d      = valu_result;
                state_d   = (round_idx_q == LAST_ROUND) ? S_DONE : S_MC;
            end
            S_MC: begin
                valu_ctrl   = VALU_MIX_COLUMNS;
                valu_op1    = st_q;
                valu_op2    = key_q;
                st_d        = valu_result;
                round_idx_d = round_idx_q + 4'd1;
                state_d     = S_KS_ROT;
            end
            S_DONE: begin
                // First DONE cycle loads the output register; it then holds until taken.
                if (!out_valid_q) begin
                    out_block_d = st_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    round_idx_d = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_valu_sequencer.sv
// Bench for aes_valu_sequencer driving a vector_alu. Reference is a byte-array
// FIPS-197 AES-128 model with its own S-box table built from GF(2^8) inverses.
module tb_aes_valu_sequencer;
    import vector_alu_pkg::*;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    // Cycle t+n spans edges t+n-1..t+n, so out_valid in cycle t+62 is seen after edge t+61.
    localparam int LATENCY = 61;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
    logic [3:0]   round_idx;
    logic [127:0] valu_op1;
    logic [127:0] valu_op2;
    logic [3:0]   valu_ctrl;
    logic [127:0] valu_result;

    int checks = 0;
    int errors = 0;
    logic [7:0] sbox_tab [0:255];

    always #5 clk = ~clk;

    aes_valu_sequencer #(.WIDTH(128), .NROUNDS(10)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .busy(busy), .round_idx(round_idx),
        .valu_op1(valu_op1), .valu_op2(valu_op2), .valu_ctrl(valu_ctrl),
        .valu_result(valu_result)
    );

    vector_alu alu (
        .op1(valu_op1), .op2(valu_op2), .ctrl(valu_ctrl), .result(valu_result)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] c63;
        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] a, b;
            a = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul_ref(8'(x), 8'(y)) == 8'h01) a = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8] ^ c63[i];
            sbox_tab[x] = b;
        end
    endtask

    function automatic logic [127:0] aes128_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] w [0:175];
        logic [7:0] s [0:15];
        logic [7:0] t [0:15];
        logic [7:0] tw [0:3];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] ct;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tw[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                a0 = tw[0];
                tw[0] = sbox_tab[tw[1]] ^ rc;
                tw[1] = sbox_tab[tw[2]];
                tw[2] = sbox_tab[tw[3]];
                tw[3] = sbox_tab[a0];
                rc = gmul_ref(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tw[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) t[4*c+rw] = s[4*((c+rw)%4)+rw];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul_ref(a0, 8'h02) ^ gmul_ref(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul_ref(a1, 8'h02) ^ gmul_ref(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul_ref(a2, 8'h02) ^ gmul_ref(a3, 8'h03);
                    t[4*c+3] = gmul_ref(a0, 8'h03) ^ a1 ^ a2 ^ gmul_ref(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_flags"}, 128'({in_ready, out_valid, busy, round_idx}), 128'({1'b1, 1'b0, 1'b0, 4'd0}));
        check_eq({tag, "_out_block"}, out_block, 128'd0);
        check_eq({tag, "_op1"}, valu_op1, 128'd0);
        check_eq({tag, "_op2"}, valu_op2, 128'd0);
        check_eq({tag, "_ctrl"}, 128'(valu_ctrl), 128'(VALU_XOR));
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One encryption: accept, optional in_valid injection mid-run, a stray out_ready
    // pulse while busy, latency check, 'hold' cycles with out_ready low, handshake.
    task automatic run_txn(input string tag, input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] exp, input int hold, input int inject_at);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 100) begin tick(); w++; end
        check_eq({tag, "_ready"}, 128'(in_ready), 128'd1);
        in_key = key; in_block = pt; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_key = rand128(); in_block = rand128();
        check_eq({tag, "_accept"}, 128'({busy, in_ready, round_idx}), 128'({1'b1, 1'b0, 4'd0}));
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            if (k == inject_at) begin in_valid = 1'b1; in_key = ~key; in_block = ~pt; end
            if (k == inject_at + 5) in_valid = 1'b0;
            out_ready = (k == 20);
            tick();
            if (out_valid) begin lat = k; break; end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        check_eq({tag, "_latency"}, 128'(lat), 128'(LATENCY));
        check_eq({tag, "_round"}, 128'(round_idx), 128'd10);
        check_eq({tag, "_ct"}, out_block, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0); in_key = rand128(); in_block = rand128();
            tick();
            check_eq({tag, "_hold_flags"}, 128'({out_valid, in_ready, busy}), 128'(3'b101));
            check_eq({tag, "_hold_ct"}, out_block, exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_idle"}, 128'({busy, in_ready, out_valid, round_idx}), 128'({1'b0, 1'b1, 1'b0, 4'd0}));
        $display("txn %s key=%h pt=%h ct=%h lat=%0d", tag, key, pt, exp, lat);
    endtask

    task automatic run_back_to_back();
        int e_acc0, e_acc1, e_hs, e_ov0, nacc, nov;
        logic prev_busy, prev_ov;
        logic [127:0] ct0, ct1;
        e_acc0 = -1; e_acc1 = -1; e_hs = -100; e_ov0 = -1; nacc = 0; nov = 0;
        ct0 = '0; ct1 = '0;
        prev_busy = busy; prev_ov = out_valid;
        in_key = K1; in_block = P1; in_valid = 1'b1; out_ready = 1'b1;
        for (int e = 1; e <= 400; e++) begin
            tick();
            if (busy && !prev_busy) begin
                if (nacc == 0) begin e_acc0 = e; in_key = K2; in_block = P2; end
                else begin e_acc1 = e; in_valid = 1'b0; end
                nacc++;
            end
            if (!busy && prev_busy && nacc == 1) e_hs = e;
            if (out_valid && !prev_ov) begin
                if (nov == 0) begin ct0 = out_block; e_ov0 = e; end
                else ct1 = out_block;
                nov++;
            end
            prev_busy = busy; prev_ov = out_valid;
            if (nov == 2) break;
        end
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        check_eq("b2b_accepts", 128'(nacc), 128'd2);
        check_eq("b2b_ct0", ct0, C1);
        check_eq("b2b_ct1", ct1, C2);
        check_eq("b2b_latency", 128'(e_ov0 - e_acc0), 128'(LATENCY));
        check_eq("b2b_gap", 128'(e_acc1 - e_hs), 128'd1);
        check_eq("b2b_idle", 128'({busy, in_ready}), 128'({1'b0, 1'b1}));
        $display("txn b2b ct0=%h ct1=%h accept_gap=%0d", ct0, ct1, e_acc1 - e_hs);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_key = '0; in_block = '0;
        build_sbox();
        repeat (2) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        run_txn("fips_b", K1, P1, C1, 0, 0);
        run_txn("fips_c1", K2, P2, C2, 0, 0);
        run_txn("hold20", K1, P1, C1, 20, 0);
        run_txn("inject30", K1, P1, C1, 0, 30);

        // Reset 25 cycles into a run; outputs must drop asynchronously.
        in_key = K1; in_block = P1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (24) tick();
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        tick();
        rst = 1'b0;
        tick();
        run_txn("after_rst", K2, P2, C2, 0, 0);

        run_back_to_back();

        for (int n = 0; n < 8; n++) begin
            logic [127:0] rk, rp;
            rk = rand128(); rp = rand128();
            run_txn($sformatf("rand%0d", n), rk, rp, aes128_ref(rk, rp), $urandom_range(0, 3), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
